// File: rtl/adder_serial_rtl.sv
`default_nettype none
// ============================================================================
// adder_serial_rtl : digit-serial (p_dbits per cycle) adder with val/rdy streams. Rev 1.0
// ============================================================================
module adder_serial_rtl #(
  parameter int p_nbits = 8,
  parameter int p_dbits = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [p_nbits-1:0] in_a,
  input  logic [p_nbits-1:0] in_b,
  input  logic               in_cin,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] out_sum,
  output logic               out_cout
);

  localparam int N  = p_nbits / p_dbits;
  localparam int CW = $clog2(N + 1);

  if (p_nbits < 1 || p_dbits < 1 || (p_nbits % p_dbits) != 0) begin : g_param_check
    $error("adder_serial_rtl: p_nbits must be a positive multiple of p_dbits");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [p_nbits-1:0] a_sh, b_sh, sum_sh, sum_q;
  logic               carry, cout_q;
  logic [CW-1:0]      cnt;
  logic [p_dbits:0]   digit;
  logic [p_nbits-1:0] sum_shifted;
  logic               last;

  assign digit = {1'b0, a_sh[p_dbits-1:0]} + {1'b0, b_sh[p_dbits-1:0]}
               + {{p_dbits{1'b0}}, carry};
  // Digits enter at the MSB end so after N shifts digit 0 sits at bit 0.
  assign sum_shifted = (sum_sh >> p_dbits)
                     | (p_nbits'(digit[p_dbits-1:0]) << (p_nbits - p_dbits));
  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) state_next = CALC;
      end
      CALC: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (istream_val) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_cin;
            cnt   <= '0;
          end
        end
        CALC: begin
          a_sh   <= a_sh >> p_dbits;
          b_sh   <= b_sh >> p_dbits;
          sum_sh <= sum_shifted;
          carry  <= digit[p_dbits];
          cnt    <= cnt + CW'(1);
          // Result registers only change on the final digit so outputs hold otherwise.
          if (last) begin
            sum_q  <= sum_shifted;
            cout_q <= digit[p_dbits];
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_serial_rtl.sv
`default_nettype none
// tb_adder_serial_rtl : scoreboard bench; directed tests on the p_dbits=2 build,
// random val/rdy traffic on the p_dbits=2, 8 and 1 builds against a plain-arithmetic model.
module tb_adder_serial_rtl;
  localparam int NB     = 8;
  localparam int K      = 3;
  localparam int OPS    = 1000;
  localparam int BUDGET = 60000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_val  [K];
  logic          in_rdy  [K];
  logic [NB-1:0] a       [K];
  logic [NB-1:0] b       [K];
  logic          cin     [K];
  logic          out_val [K];
  logic          out_rdy [K];
  logic [NB-1:0] sum     [K];
  logic          cout    [K];

  int checks   = 0;
  int failures = 0;
  logic [NB:0] q0[$];
  logic [NB:0] q1[$];
  logic [NB:0] q2[$];

  always #5 clk = ~clk;

  adder_serial_rtl #(.p_nbits(NB), .p_dbits(2)) u_d2 (
    .clk(clk), .reset(reset),
    .istream_val(in_val[0]), .istream_rdy(in_rdy[0]),
    .in_a(a[0]), .in_b(b[0]), .in_cin(cin[0]),
    .ostream_val(out_val[0]), .ostream_rdy(out_rdy[0]),
    .out_sum(sum[0]), .out_cout(cout[0])
  );

  adder_serial_rtl #(.p_nbits(NB), .p_dbits(8)) u_d8 (
    .clk(clk), .reset(reset),
    .istream_val(in_val[1]), .istream_rdy(in_rdy[1]),
    .in_a(a[1]), .in_b(b[1]), .in_cin(cin[1]),
    .ostream_val(out_val[1]), .ostream_rdy(out_rdy[1]),
    .out_sum(sum[1]), .out_cout(cout[1])
  );

  adder_serial_rtl #(.p_nbits(NB), .p_dbits(1)) u_d1 (
    .clk(clk), .reset(reset),
    .istream_val(in_val[2]), .istream_rdy(in_rdy[2]),
    .in_a(a[2]), .in_b(b[2]), .in_cin(cin[2]),
    .ostream_val(out_val[2]), .ostream_rdy(out_rdy[2]),
    .out_sum(sum[2]), .out_cout(cout[2])
  );

  function automatic logic [NB:0] model(input logic [NB-1:0] x, input logic [NB-1:0] y,
                                        input logic c);
    return {1'b0, x} + {1'b0, y} + {{NB{1'b0}}, c};
  endfunction

  function automatic void qpush(input int k, input logic [NB:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic logic [NB:0] qpop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set to the dbits=2 instance; returns one cycle after acceptance.
  task automatic send0(input logic [NB-1:0] x, input logic [NB-1:0] y, input logic c);
    check("idle_rdy", int'(in_rdy[0]), 1);
    a[0] = x; b[0] = y; cin[0] = c; in_val[0] = 1'b1;
    qpush(0, model(x, y, c));
    tick();
    in_val[0] = 1'b0;
  endtask

  task automatic wait_done0(output int n);
    n = 0;
    while (!out_val[0] && n < 50) begin
      check("calc_rdy", int'(in_rdy[0]), 0);
      tick();
      n++;
    end
  endtask

  task automatic run0(input logic [NB-1:0] x, input logic [NB-1:0] y, input logic c,
                      input logic [NB:0] exp);
    int n;
    send0(x, y, c);
    wait_done0(n);
    check("latency", n, 4);
    check("result", int'({cout[0], sum[0]}), int'(exp));
    check("done_rdy", int'(in_rdy[0]), 0);
    tick();
    check("back_idle_rdy", int'(in_rdy[0]), 1);
    check("back_idle_val", int'(out_val[0]), 0);
  endtask

  // Pops the scoreboard on every output handshake and checks that stalled outputs stay put.
  initial begin : monitor
    logic [NB:0] held [K];
    logic        hold [K];
    for (int k = 0; k < K; k++) begin
      hold[k] = 1'b0;
      held[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < K; k++) begin
        if (reset || !out_val[k]) begin
          hold[k] = 1'b0;
        end else begin
          if (hold[k])
            check($sformatf("hold%0d", k), int'({cout[k], sum[k]}), int'(held[k]));
          if (out_rdy[k]) begin
            if (qsize(k) == 0) check($sformatf("spurious%0d", k), int'(out_val[k]), 0);
            else check($sformatf("sum%0d", k), int'({cout[k], sum[k]}), int'(qpop(k)));
            hold[k] = 1'b0;
          end else begin
            hold[k] = 1'b1;
            held[k] = {cout[k], sum[k]};
          end
        end
      end
    end
  end

  initial begin : driver
    int n;
    int cyc;
    int sent [K];
    for (int k = 0; k < K; k++) begin
      in_val[k] = 1'b0; a[k] = '0; b[k] = '0; cin[k] = 1'b0; out_rdy[k] = 1'b1;
      sent[k] = 0;
    end
    reset = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < K; k++) begin
      check($sformatf("rst_rdy%0d", k), int'(in_rdy[k]), 1);
      check($sformatf("rst_val%0d", k), int'(out_val[k]), 0);
      check($sformatf("rst_out%0d", k), int'({cout[k], sum[k]}), 0);
    end
    reset = 1'b0;

    run0(8'h3C, 8'h41, 1'b0, 9'h07D);
    run0(8'hFF, 8'h01, 1'b0, 9'h100);
    run0(8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // Backpressure in DONE
    out_rdy[0] = 1'b0;
    send0(8'hA5, 8'h5A, 1'b1);
    wait_done0(n);
    check("bp_latency", n, 4);
    repeat (3) begin
      check("bp_val", int'(out_val[0]), 1);
      check("bp_rdy", int'(in_rdy[0]), 0);
      check("bp_out", int'({cout[0], sum[0]}), 9'h100);
      tick();
    end
    out_rdy[0] = 1'b1;
    check("bp_val_last", int'(out_val[0]), 1);
    tick();
    check("bp_idle_rdy", int'(in_rdy[0]), 1);
    check("bp_idle_val", int'(out_val[0]), 0);

    // Reset during the second CALC cycle discards the operation
    send0(8'h77, 8'h11, 1'b0);
    tick();
    reset = 1'b1;
    q0.delete();
    tick();
    reset = 1'b0;
    check("mid_rst_rdy", int'(in_rdy[0]), 1);
    check("mid_rst_val", int'(out_val[0]), 0);
    check("mid_rst_out", int'({cout[0], sum[0]}), 0);
    run0(8'h10, 8'h20, 1'b0, 9'h030);

    // Operand changes and a stray valid during CALC/DONE are ignored
    send0(8'h12, 8'h34, 1'b1);
    a[0] = 8'h00; b[0] = 8'h00; in_val[0] = 1'b1;
    wait_done0(n);
    check("chg_latency", n, 4);
    check("chg_result", int'({cout[0], sum[0]}), 9'h047);
    check("chg_done_rdy", int'(in_rdy[0]), 0);
    in_val[0] = 1'b0;
    tick();
    check("chg_idle_rdy", int'(in_rdy[0]), 1);
    tick();

    // Random traffic with val/rdy stalls on all three builds
    cyc = 0;
    while ((sent[0] < OPS || sent[1] < OPS || sent[2] < OPS) && cyc < BUDGET) begin
      for (int k = 0; k < K; k++) begin
        out_rdy[k] = ($urandom_range(0, 3) != 0);
        a[k]       = 8'($urandom);
        b[k]       = 8'($urandom);
        cin[k]     = 1'($urandom_range(0, 1));
        in_val[k]  = (sent[k] < OPS) && ($urandom_range(0, 3) != 0);
        if (in_val[k] && in_rdy[k]) begin
          qpush(k, model(a[k], b[k], cin[k]));
          sent[k]++;
        end
      end
      tick();
      cyc++;
    end
    check("stim_budget", int'(cyc < BUDGET), 1);
    for (int k = 0; k < K; k++) begin
      in_val[k]  = 1'b0;
      out_rdy[k] = 1'b1;
    end
    cyc = 0;
    while ((qsize(0) + qsize(1) + qsize(2)) != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    for (int k = 0; k < K; k++) check($sformatf("drain%0d", k), qsize(k), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
